// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU/load results per cycle, extends load data, registers the RF write port.
// Latency 1 cycle; readies are combinational, load has priority unless the ALU has starved STARVE_LIMIT cycles.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [63:0] ld_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic        write_enable,
  output logic [4:0]  waddr,
  output logic [63:0] wdata,
  output logic [63:0] retired
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  r_starve;
  logic        r_we;
  logic [4:0]  r_waddr;
  logic [63:0] r_wdata;
  logic [63:0] r_retired;

  logic        w_ld_ready;
  logic        w_alu_ready;
  logic        w_accept;
  logic        w_starved;
  logic [4:0]  w_win_rd;
  logic [63:0] w_win_data;
  logic [63:0] w_ld_ext;

  assign w_starved   = (r_starve == LP_LIMIT);
  assign w_ld_ready  = ld_valid & ~(alu_valid & w_starved);
  assign w_alu_ready = alu_valid & ~w_ld_ready;
  assign w_accept    = w_ld_ready | w_alu_ready;

  always_comb begin
    w_ld_ext = ld_data;
    case (ld_size)
      2'b00:   w_ld_ext = {{56{~ld_unsigned & ld_data[7]}},  ld_data[7:0]};
      2'b01:   w_ld_ext = {{48{~ld_unsigned & ld_data[15]}}, ld_data[15:0]};
      2'b10:   w_ld_ext = {{32{~ld_unsigned & ld_data[31]}}, ld_data[31:0]};
      default: w_ld_ext = ld_data;
    endcase
  end

  assign w_win_rd   = w_ld_ready ? ld_rd    : alu_rd;
  assign w_win_data = w_ld_ready ? w_ld_ext : alu_data;

  // Starvation only accumulates while the ALU is actually waiting; it saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (alu_valid && !w_alu_ready) begin
      if (!w_starved) r_starve <= r_starve + 4'd1;
    end else begin
      r_starve <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_waddr   <= 5'd0;
      r_wdata   <= 64'd0;
      r_retired <= 64'd0;
    end else if (w_accept) begin
      r_we      <= (w_win_rd != 5'd0);
      r_waddr   <= w_win_rd;
      r_wdata   <= w_win_data;
      r_retired <= r_retired + 64'd1;
    end else begin
      r_we      <= 1'b0;
    end
  end

  assign ld_ready     = w_ld_ready;
  assign alu_ready    = w_alu_ready;
  assign write_enable = r_we;
  assign waddr        = r_waddr;
  assign wdata        = r_wdata;
  assign retired      = r_retired;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a reference model predicts each acceptance and queues the expected
// register-file write, which is popped and compared one cycle later.
module tb_wb_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        write_enable;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [63:0] retired;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [63:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned m_starve = 0;
  logic [4:0]  m_addr   = '0;
  logic [63:0] m_data   = '0;
  logic [63:0] m_ret    = '0;
  byte         last_win;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [1:0] sz, input logic uns);
    int          nb;
    logic [63:0] mask;
    logic [63:0] v;
    if (sz == 2'b11) return d;
    nb   = 8 << sz;
    mask = (64'd1 << nb) - 64'd1;
    v    = d & mask;
    if (!uns && d[nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic void model_reset();
    m_starve = 0;
    m_addr   = '0;
    m_data   = '0;
    m_ret    = '0;
    sb.delete();
  endfunction

  // Called just after a rising edge with inputs already driven; returns just after the next rising edge.
  task automatic step(input string tag);
    logic ld_win, alu_win;
    exp_t e;
    #1;
    ld_win  = ld_valid && !(alu_valid && (m_starve == LIMIT));
    alu_win = alu_valid && !ld_win;
    check({tag, ".ld_ready"},  64'(ld_ready),  64'(ld_win));
    check({tag, ".alu_ready"}, 64'(alu_ready), 64'(alu_win));
    last_win = ld_win ? "L" : (alu_win ? "A" : "-");
    e.we = 1'b0;
    if (ld_win) begin
      m_addr = ld_rd;
      m_data = ext_model(ld_data, ld_size, ld_unsigned);
      e.we   = (ld_rd != 0);
      m_ret  = m_ret + 1;
    end else if (alu_win) begin
      m_addr = alu_rd;
      m_data = alu_data;
      e.we   = (alu_rd != 0);
      m_ret  = m_ret + 1;
    end
    e.addr = m_addr;
    e.data = m_data;
    e.ret  = m_ret;
    sb.push_back(e);
    if (alu_valid && !alu_win) m_starve = (m_starve == LIMIT) ? LIMIT : m_starve + 1;
    else                       m_starve = 0;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".we"},      64'(write_enable), 64'(e.we));
      check({tag, ".waddr"},   64'(waddr),        64'(e.addr));
      check({tag, ".wdata"},   wdata,             e.data);
      check({tag, ".retired"}, retired,           e.ret);
    end
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [63:0] d,
                          input logic [1:0] sz, input logic uns);
    ld_valid = v; ld_rd = rd; ld_data = d; ld_size = sz; ld_unsigned = uns;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  string       pat;
  logic [63:0] ret_base;

  initial begin
    pat = "LLLLALLLLA";
    rst_n = 1'b0;
    drive_alu(1'b1, 5'd3, 64'h1111);
    drive_ld(1'b1, 5'd9, 64'h0000_0000_0000_0042, 2'b11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.we",      64'(write_enable), 64'd0);
    check("rst.waddr",   64'(waddr),        64'd0);
    check("rst.wdata",   wdata,             64'd0);
    check("rst.retired", retired,           64'd0);
    check("rst.alu_ready_low", 64'(alu_ready), 64'd0);
    model_reset();
    rst_n = 1'b1;
    step("first_is_load");
    check("first_is_load.win", 64'(last_win), 64'("L"));

    drive_alu(1'b0, 5'd0, 64'd0);
    drive_ld(1'b0, 5'd0, 64'd0, 2'b00, 1'b0);
    step("idle");

    drive_alu(1'b1, 5'd5, 64'h1234);
    step("alu_single");
    check("alu_single.wdata_const", wdata, 64'h1234);
    drive_alu(1'b0, 5'd0, 64'd0);

    drive_ld(1'b1, 5'd10, 64'h80, 2'b00, 1'b0);
    step("ld_b_signed");
    check("ld_b_signed.const", wdata, 64'hFFFF_FFFF_FFFF_FF80);
    drive_ld(1'b1, 5'd11, 64'h80, 2'b00, 1'b1);
    step("ld_b_unsigned");
    check("ld_b_unsigned.const", wdata, 64'h80);
    drive_ld(1'b1, 5'd12, 64'h0000_0000_8000_0000, 2'b10, 1'b0);
    step("ld_w_signed");
    check("ld_w_signed.const", wdata, 64'hFFFF_FFFF_8000_0000);
    drive_ld(1'b1, 5'd13, 64'hABCD_0000_0000_F00D, 2'b01, 1'b0);
    step("ld_h_signed");
    check("ld_h_signed.const", wdata, 64'hFFFF_FFFF_FFFF_F00D);
    drive_ld(1'b1, 5'd14, 64'h8000_0000_0000_0001, 2'b11, 1'b1);
    step("ld_d_unsigned_ignored");
    check("ld_d.const", wdata, 64'h8000_0000_0000_0001);
    for (int i = 0; i < 16; i++) begin
      drive_ld(1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom},
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      step("ld_rand");
    end
    drive_ld(1'b0, 5'd0, 64'd0, 2'b00, 1'b0);
    step("idle2");

    ret_base = retired;
    drive_alu(1'b1, 5'd20, 64'hA0);
    drive_ld(1'b1, 5'd21, 64'hB0, 2'b11, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("contend");
      check("contend.pattern", 64'(last_win), 64'(pat[i]));
      if (last_win == "L") drive_ld(1'b1, 5'(22 + i), 64'hB1 + 64'(i), 2'b11, 1'b0);
      else                 drive_alu(1'b1, 5'(20 + i), 64'hA1 + 64'(i));
    end
    check("contend.retired10", retired - ret_base, 64'd10);
    drive_alu(1'b0, 5'd0, 64'd0);
    drive_ld(1'b0, 5'd0, 64'd0, 2'b00, 1'b0);
    step("idle3");

    drive_alu(1'b1, 5'd0, 64'hDEAD);
    step("x0");
    check("x0.we_low", 64'(write_enable), 64'd0);

    for (int i = 1; i <= 4; i++) begin
      drive_alu(1'b1, 5'(i), 64'(i * 3));
      step("alu_b2b");
    end

    drive_alu(1'b1, 5'd7, 64'h7777);
    step("pre_reset");
    check("pre_reset.we_high", 64'(write_enable), 64'd1);
    drive_alu(1'b0, 5'd0, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.we",      64'(write_enable), 64'd0);
    check("async_rst.waddr",   64'(waddr),        64'd0);
    check("async_rst.retired", retired,           64'd0);
    check("async_rst.ready",   64'(ld_ready | alu_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("in_rst.we_at_edge", 64'(write_enable), 64'd0);
    rst_n = 1'b1;
    step("post_reset_idle");
    drive_ld(1'b1, 5'd8, 64'hFF, 2'b00, 1'b1);
    step("post_reset_ld");
    drive_ld(1'b0, 5'd0, 64'd0, 2'b00, 1'b0);
    step("final_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
